// File: rtl/x25519_operand_loader.sv
// x25519_operand_loader: byte-stream front end for the Montgomery-ladder
// scalar multiplier. Collects 32 scalar bytes then 32 u-coordinate bytes
// (little-endian), clamps the scalar, reduces u mod 2^255-19, then releases
// the multiplier from reset and captures its x_q result.
// Optional build macro: X25519_LOWORDER_CHECK_EN (err accompanies a zero result).
//
// state  | meaning
// IDLE   | waiting for byte 0; multiplier held in reset
// LOAD   | collecting bytes 1..63 into the scalar/u buffers
// REDUCE | one cycle: clamp scalar, reduce u, register k_out/xp_out
// RUN    | multiplier running; wait for core_done or watchdog expiry
module x25519_operand_loader #(
    parameter int CLAMP    = 1,
    parameter int WATCHDOG = 0
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [7:0]   in_data,
    input  logic         in_last,
    output logic [254:0] k_out,
    output logic [254:0] xp_out,
    output logic         core_rst,
    input  logic         core_done,
    input  logic [254:0] core_xq,
    output logic [254:0] result,
    output logic         result_valid,
    output logic         err,
    output logic         busy
);

    typedef enum logic [1:0] {S_IDLE, S_LOAD, S_REDUCE, S_RUN} state_t;

    // 2^255 - 19: all ones except the low five bits 0b01101
    localparam logic [254:0] P_MOD   = {{250{1'b1}}, 5'b01101};
    localparam logic [31:0]  WD_LAST = (WATCHDOG > 0) ? 32'(WATCHDOG - 1) : 32'd0;

    state_t         state, state_nxt;
    logic [5:0]     byte_cnt;
    logic [31:0]    wd_cnt;
    logic [255:0]   scal_buf;
    logic [255:0]   u_buf;
    logic           rv_nxt;
    logic           err_nxt;
    logic           accept;
    logic           last_byte;
    logic           frame_err;
    logic           wd_hit;
    logic           low_order;
    logic [254:0]   k_red;
    logic [254:0]   u_masked;
    logic [254:0]   xp_red;
    logic           unused_bits;

    assign in_ready  = rst && ((state == S_IDLE) || (state == S_LOAD));
    assign busy      = (state != S_IDLE);
    assign accept    = in_valid && in_ready;
    assign last_byte = (byte_cnt == 6'd63);
    assign frame_err = accept && (in_last != last_byte);
    // Counter holds the number of completed RUN cycles, so expiry fires at the
    // end of RUN cycle number WATCHDOG.
    assign wd_hit    = (WATCHDOG > 0) && (wd_cnt == WD_LAST);

`ifdef X25519_LOWORDER_CHECK_EN
    assign low_order = (core_xq == '0);
`else
    assign low_order = 1'b0;
`endif

    // Bit 255 of each buffer is dropped by design.
    assign unused_bits = ^{scal_buf[255], u_buf[255]};

    assign k_red    = (CLAMP != 0) ? {1'b1, scal_buf[253:3], 3'b000} : scal_buf[254:0];
    assign u_masked = u_buf[254:0];
    // Masked u is below 2^255 < 2p, so one conditional subtract is a full reduction.
    assign xp_red   = (u_masked >= P_MOD) ? (u_masked - P_MOD) : u_masked;

    // Next-state and strobe decode
    always_comb begin
        state_nxt = state;
        rv_nxt    = 1'b0;
        err_nxt   = 1'b0;
        case (state)
            S_IDLE: begin
                if (accept) begin
                    state_nxt = frame_err ? S_IDLE : S_LOAD;
                    err_nxt   = frame_err;
                end
            end
            S_LOAD: begin
                if (frame_err) begin
                    state_nxt = S_IDLE;
                    err_nxt   = 1'b1;
                end else if (accept && last_byte) begin
                    state_nxt = S_REDUCE;
                end
            end
            S_REDUCE: begin
                state_nxt = S_RUN;
            end
            S_RUN: begin
                if (core_done) begin
                    state_nxt = S_IDLE;
                    rv_nxt    = 1'b1;
                    err_nxt   = low_order;
                end else if (wd_hit) begin
                    state_nxt = S_IDLE;
                    err_nxt   = 1'b1;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // State register
    always_ff @(posedge clk) begin
        if (!rst) state <= S_IDLE;
        else      state <= state_nxt;
    end

    // Byte counter, operand buffers and watchdog counter
    always_ff @(posedge clk) begin
        if (!rst) begin
            byte_cnt <= '0;
            wd_cnt   <= '0;
            scal_buf <= '0;
            u_buf    <= '0;
        end else begin
            if (accept) begin
                if (byte_cnt[5]) u_buf[{byte_cnt[4:0], 3'b000} +: 8]    <= in_data;
                else             scal_buf[{byte_cnt[4:0], 3'b000} +: 8] <= in_data;
                byte_cnt <= (frame_err || last_byte) ? 6'd0 : byte_cnt + 6'd1;
            end
            wd_cnt <= (state == S_RUN) ? wd_cnt + 32'd1 : 32'd0;
        end
    end

    // Registered outputs; core_rst drops one cycle into RUN so k_out/xp_out
    // have been stable for a full cycle before the multiplier leaves reset.
    always_ff @(posedge clk) begin
        if (!rst) begin
            k_out        <= '0;
            xp_out       <= '0;
            result       <= '0;
            core_rst     <= 1'b1;
            result_valid <= 1'b0;
            err          <= 1'b0;
        end else begin
            result_valid <= rv_nxt;
            err          <= err_nxt;
            core_rst     <= !((state == S_RUN) && (state_nxt == S_RUN));
            if (state == S_REDUCE) begin
                k_out  <= k_red;
                xp_out <= xp_red;
            end
            if ((state == S_RUN) && core_done) result <= core_xq;
        end
    end

endmodule

// File: tb/tb_x25519_operand_loader.sv
// Directed bench for x25519_operand_loader (CLAMP=1, WATCHDOG=100).
module tb_x25519_operand_loader;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [7:0]   in_data;
    logic         in_last;
    logic [254:0] k_out;
    logic [254:0] xp_out;
    logic         core_rst;
    logic         core_done;
    logic [254:0] core_xq;
    logic [254:0] result;
    logic         result_valid;
    logic         err;
    logic         busy;

    int checks   = 0;
    int failures = 0;

    localparam logic [254:0] P_VAL  = ~255'd18;   // 2^255-19
    localparam logic [254:0] K_FF   = ~255'd7;    // 0x7FF..F8
    localparam logic [254:0] K_ZERO = 255'd1 << 254;

    x25519_operand_loader #(.CLAMP(1), .WATCHDOG(100)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .in_data(in_data), .in_last(in_last), .k_out(k_out), .xp_out(xp_out),
        .core_rst(core_rst), .core_done(core_done), .core_xq(core_xq),
        .result(result), .result_valid(result_valid), .err(err), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_val(input string tag, input logic [254:0] got, input logic [254:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Sends the 64-byte stream; in_last on byte last_at (-1 = never). Stops after last_at.
    task automatic load_op(input logic [255:0] s, input logic [255:0] u, input int last_at);
        for (int i = 0; i < 64; i++) begin
            if (i < 32) in_data = s[8*i +: 8];
            else        in_data = u[8*(i-32) +: 8];
            in_last  = (i == last_at);
            in_valid = 1'b1;
            tick();
            in_valid = 1'b0;
            in_last  = 1'b0;
            if (i == last_at) break;
        end
    endtask

    // Full transaction: load, check operands and reset release, finish with core_done.
    task automatic do_run(input string tag, input logic [255:0] s, input logic [255:0] u,
                          input logic [254:0] exp_k, input logic [254:0] exp_xp,
                          input logic [254:0] xq);
        load_op(s, u, 63);
        check_val({tag, "_rst_hold0"}, core_rst, 1);
        tick();
        check_val({tag, "_rst_hold1"}, core_rst, 1);
        check_val({tag, "_k"}, k_out, exp_k);
        check_val({tag, "_xp"}, xp_out, exp_xp);
        // in_ready low outside IDLE/LOAD: this byte must be ignored
        in_valid = 1'b1;
        in_data  = 8'hA5;
        tick();
        in_valid = 1'b0;
        check_val({tag, "_rst_fall"}, core_rst, 0);
        check_val({tag, "_ready_run"}, in_ready, 0);
        core_done = 1'b1;
        core_xq   = xq;
        tick();
        core_done = 1'b0;
        check_val({tag, "_rv"}, result_valid, 1);
        check_val({tag, "_result"}, result, xq);
        check_val({tag, "_core_rst_back"}, core_rst, 1);
`ifdef X25519_LOWORDER_CHECK_EN
        check_val({tag, "_err_done"}, err, (xq == '0));
`else
        check_val({tag, "_err_done"}, err, 0);
`endif
        tick();
        check_val({tag, "_rv_pulse"}, result_valid, 0);
        check_val({tag, "_busy_idle"}, busy, 0);
    endtask

    task automatic check_reset_vals(input string tag);
        check_val({tag, "_core_rst"}, core_rst, 1);
        check_val({tag, "_in_ready"}, in_ready, 0);
        check_val({tag, "_busy"}, busy, 0);
        check_val({tag, "_err"}, err, 0);
        check_val({tag, "_rv"}, result_valid, 0);
        check_val({tag, "_k"}, k_out, '0);
        check_val({tag, "_xp"}, xp_out, '0);
        check_val({tag, "_result"}, result, '0);
    endtask

    // Loads a stream and runs into RUN, returning after core_rst has dropped.
    task automatic enter_run(input logic [255:0] s, input logic [255:0] u);
        load_op(s, u, 63);
        tick();
        tick();
    endtask

    initial begin
        rst = 1'b0; in_valid = 1'b0; in_data = '0; in_last = 1'b0;
        core_done = 1'b0; core_xq = '0;
        tick();
        check_reset_vals("reset");
        rst = 1'b1;
        tick();
        check_val("ready_idle", in_ready, 1);

        do_run("basic", {256{1'b1}}, 256'd9, K_FF, 255'd9, 255'h1234);
        do_run("u_max", 256'd0, {256{1'b1}}, K_ZERO, 255'd18, 255'h55);
        do_run("u_p", 256'd0, {1'b0, P_VAL}, K_ZERO, 255'd0, 255'h1);
        do_run("u_pm1", 256'd0, {1'b0, P_VAL - 255'd1}, K_ZERO, P_VAL - 255'd1, 255'h2);
        do_run("u_bit255", 256'd0, (256'd1 << 255) | 256'd5, K_ZERO, 255'd5, 255'h3);
        do_run("loworder", {256{1'b1}}, 256'd9, K_FF, 255'd9, 255'd0);

        // Early in_last on byte 40
        load_op(256'h77, 256'h66, 40);
        check_val("early_err", err, 1);
        check_val("early_busy", busy, 0);
        check_val("early_core_rst", core_rst, 1);
        check_val("early_k", k_out, K_FF);
        check_val("early_xp", xp_out, 255'd9);
        tick();
        check_val("early_err_pulse", err, 0);

        // Byte 63 without in_last
        load_op(256'h77, 256'h66, -1);
        check_val("nolast_err", err, 1);
        check_val("nolast_busy", busy, 0);
        check_val("nolast_k", k_out, K_FF);
        check_val("nolast_xp", xp_out, 255'd9);
        tick();

        // Watchdog expiry: 100th RUN cycle ends 99 edges after core_rst fell
        enter_run(256'd0, 256'd7);
        check_val("wd_run_rst", core_rst, 0);
        repeat (98) tick();
        check_val("wd_early_err", err, 0);
        check_val("wd_early_busy", busy, 1);
        tick();
        check_val("wd_err", err, 1);
        check_val("wd_core_rst", core_rst, 1);
        check_val("wd_rv", result_valid, 0);
        check_val("wd_result_kept", result, 255'd0);
        check_val("wd_busy", busy, 0);
        tick();

        // core_done in the expiry cycle wins
        enter_run(256'd0, 256'd7);
        repeat (98) tick();
        core_done = 1'b1;
        core_xq   = 255'hBEEF;
        tick();
        core_done = 1'b0;
        check_val("tie_rv", result_valid, 1);
        check_val("tie_err", err, 0);
        check_val("tie_result", result, 255'hBEEF);
        tick();

        // Reset during byte 20
        for (int i = 0; i < 20; i++) begin
            in_data = 8'(i); in_valid = 1'b1; in_last = 1'b0;
            tick();
        end
        rst = 1'b0;
        tick();
        in_valid = 1'b0;
        check_reset_vals("rst_load");
        rst = 1'b1;
        tick();

        // Reset during RUN
        enter_run({256{1'b1}}, 256'd9);
        rst = 1'b0;
        tick();
        check_reset_vals("rst_run");
        rst = 1'b1;
        tick();

        do_run("post_rst", 256'd0, {256{1'b1}}, K_ZERO, 255'd18, 255'h99);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
